// File: rtl/block_mode_engine_if.sv
// Stream and cipher-core bus for block_mode_engine.
//   in_*     : input block stream (valid/ready), driven by the source
//   out_*    : output block stream (valid/ready), out_last marks final block
//   cipher_* : start/done port pair to an external keystream cipher core
// master = engine side, slave = source/sink/cipher side.
interface block_mode_engine_if #(
    parameter int BLOCK_SIZE = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BLOCK_SIZE-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [BLOCK_SIZE-1:0] out_data;
    logic                  out_last;
    logic                  cipher_start;
    logic [BLOCK_SIZE-1:0] cipher_in;
    logic [BLOCK_SIZE-1:0] cipher_out;
    logic                  cipher_done;

    modport master (
        input  in_valid, in_data, out_ready, cipher_out, cipher_done,
        output in_ready, out_valid, out_data, out_last, cipher_start, cipher_in
    );

    modport slave (
        output in_valid, in_data, out_ready, cipher_out, cipher_done,
        input  in_ready, out_valid, out_data, out_last, cipher_start, cipher_in
    );
endinterface

// File: rtl/block_mode_engine.sv
// block_mode_engine: streams blocks through CTR, OFB or CFB (enc/dec) using an
// external keystream cipher core. One block in flight at a time.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : request, accepted only when idle
//   mode, decrypt     : 00 CTR, 01 OFB, 10 CFB, 11 rejected; CFB direction
//   iv, num_blocks    : initial feedback value and message length
//   bus (master)      : input/output block streams and cipher core port pair
//   busy              : engine not idle
//   done              : one-cycle pulse at end of message
//   ctr_wrap          : sticky, CTR low field wrapped during this message
//   err               : one-cycle pulse for a rejected start (mode 11)
module block_mode_engine #(
    parameter int BLOCK_SIZE = 64,
    parameter int CTR_BITS   = 32,
    parameter int LEN_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  decrypt,
    input  logic [BLOCK_SIZE-1:0] iv,
    input  logic [LEN_BITS-1:0]   num_blocks,
    block_mode_engine_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  ctr_wrap,
    output logic                  err
);
    localparam logic [1:0] M_CTR = 2'b00;
    localparam logic [1:0] M_OFB = 2'b01;
    localparam logic [1:0] M_BAD = 2'b11;

    // Bits of the feedback register that count in CTR mode.
    localparam logic [BLOCK_SIZE-1:0] LO_MASK =
        {BLOCK_SIZE{1'b1}} >> (BLOCK_SIZE - CTR_BITS);

    typedef enum logic [2:0] {IDLE, GEN, WAIT, XIN, XOUT, DONE} state_t;

    typedef struct packed {
        logic [1:0]          mode;
        logic                decrypt;
        logic [LEN_BITS-1:0] nblk;
    } req_t;

    state_t                state;
    req_t                  req;
    logic [BLOCK_SIZE-1:0] fb;
    logic [BLOCK_SIZE-1:0] ks;
    logic [LEN_BITS-1:0]   blk;
    logic [BLOCK_SIZE-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  cipher_start_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ctr_wrap_q;
    logic                  err_q;

    logic [BLOCK_SIZE-1:0] xored;
    logic [BLOCK_SIZE-1:0] fb_ctr;
    logic [BLOCK_SIZE-1:0] fb_nxt;

    assign bus.in_ready     = (state == XIN);
    assign bus.cipher_start = cipher_start_q;
    assign bus.cipher_in    = fb;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_last     = out_last_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign ctr_wrap         = ctr_wrap_q;
    assign err              = err_q;

    always_comb begin
        xored  = bus.in_data ^ ks;
        // Increment only the counter field; upper bits keep the nonce.
        fb_ctr = (fb & ~LO_MASK) | ((fb + 1'b1) & LO_MASK);
        case (req.mode)
            M_CTR:   fb_nxt = fb_ctr;
            M_OFB:   fb_nxt = ks;
            default: fb_nxt = req.decrypt ? bus.in_data : xored;
        endcase
    end

    // cipher_start, busy and done are registered: set on the transition into
    // GEN / out of IDLE / into DONE so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            req            <= '0;
            fb             <= '0;
            ks             <= '0;
            blk            <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            cipher_start_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ctr_wrap_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            err_q          <= 1'b0;
            cipher_start_q <= 1'b0;
            done_q         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == M_BAD) begin
                            err_q <= 1'b1;
                        end else if (num_blocks == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b1;
                        end else begin
                            req.mode       <= mode;
                            req.decrypt    <= decrypt;
                            req.nblk       <= num_blocks;
                            fb             <= iv;
                            blk            <= '0;
                            ctr_wrap_q     <= 1'b0;
                            state          <= GEN;
                            cipher_start_q <= 1'b1;
                            busy_q         <= 1'b1;
                        end
                    end
                end
                GEN: state <= WAIT;
                WAIT: begin
                    if (bus.cipher_done) begin
                        ks    <= bus.cipher_out;
                        state <= XIN;
                    end
                end
                XIN: begin
                    if (bus.in_valid) begin
                        out_data_q  <= xored;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (blk == req.nblk - 1'b1);
                        fb          <= fb_nxt;
                        if (req.mode == M_CTR && (fb & LO_MASK) == LO_MASK)
                            ctr_wrap_q <= 1'b1;
                        state <= XOUT;
                    end
                end
                XOUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            blk            <= blk + 1'b1;
                            state          <= GEN;
                            cipher_start_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_mode_engine.sv
module tb_block_mode_engine;
    localparam logic [63:0] K = 64'hA5A5_A5A5_A5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        decrypt = 1'b0;
    logic [63:0] iv = '0;
    logic [15:0] num_blocks = '0;
    logic        busy, done, ctr_wrap, err;

    block_mode_engine_if #(.BLOCK_SIZE(64)) bus ();

    block_mode_engine #(.BLOCK_SIZE(64), .CTR_BITS(32), .LEN_BITS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .decrypt(decrypt),
        .iv(iv), .num_blocks(num_blocks), .bus(bus),
        .busy(busy), .done(done), .ctr_wrap(ctr_wrap), .err(err)
    );

    always #5 clk = ~clk;

    // Cipher core model: E(x) = x ^ K, done 3 cycles after start. Not reset,
    // so a request in flight at reset delivers a stale done afterwards.
    logic [2:0]  vld_pipe = '0;
    logic [63:0] ks_q = '0;
    int          cs_cnt = 0;
    always_ff @(posedge clk) begin
        vld_pipe <= {vld_pipe[1:0], bus.cipher_start};
        if (bus.cipher_start) begin
            ks_q   <= bus.cipher_in ^ K;
            cs_cnt <= cs_cnt + 1;
        end
    end
    assign bus.cipher_done = vld_pipe[2];
    assign bus.cipher_out  = ks_q;

    int total = 0;
    int bad = 0;

    logic [63:0] pt[8], res[8], e_out[8], e_cin[8], orig[8];
    bit          e_wrap[8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: mode definitions written directly over the block sequence.
    function automatic void model(input logic [1:0] m, input logic d,
                                  input logic [63:0] ivv, input int n);
        logic [63:0] prev;
        logic [31:0] lo;
        bit          w;
        prev = ivv;
        w    = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (m == 2'b00) begin
                lo      = ivv[31:0] + 32'(i);
                e_cin[i] = {ivv[63:32], lo};
                if (lo == 32'hFFFF_FFFF) w = 1'b1;
                e_out[i] = pt[i] ^ (e_cin[i] ^ K);
            end else if (m == 2'b01) begin
                e_cin[i] = prev;
                e_out[i] = pt[i] ^ (prev ^ K);
                prev     = prev ^ K;
            end else begin
                e_cin[i] = prev;
                e_out[i] = pt[i] ^ (prev ^ K);
                prev     = d ? pt[i] : e_out[i];
            end
            e_wrap[i] = w;
        end
    endfunction

    task automatic run_msg(input logic [1:0] m, input logic d, input logic [63:0] ivv,
                           input int n, input int stall, input bit mid_start);
        int k, w, cs0;
        model(m, d, ivv, n);
        cs0 = cs_cnt;
        mode = m; decrypt = d; iv = ivv; num_blocks = 16'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 2'($urandom); decrypt = 1'($urandom); iv = {$urandom, $urandom};
        chk("busy_start", busy, 1);
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!bus.cipher_start && w < 20) begin @(negedge clk); w++; end
            if (!bus.cipher_start) begin chk("cstart_timeout", 0, 1); return; end
            chk("cipher_in", bus.cipher_in, e_cin[i]);
            w = 0;
            while (!bus.in_ready && w < 20) begin @(negedge clk); w++; end
            if (!bus.in_ready) begin chk("in_ready_timeout", 0, 1); return; end
            bus.in_valid = 1'b1; bus.in_data = pt[i];
            @(negedge clk);
            bus.in_valid = 1'b0; bus.in_data = {$urandom, $urandom};
            chk("out_valid", bus.out_valid, 1);
            chk("out_data", bus.out_data, e_out[i]);
            chk("out_last", bus.out_last, 64'(i == n - 1));
            chk("ctr_wrap", ctr_wrap, 64'(e_wrap[i]));
            res[i] = bus.out_data;
            k = (stall < 0) ? $urandom_range(0, 3) : stall;
            repeat (k) begin
                if (mid_start) begin
                    start = 1'b1; mode = 2'b00; iv = '0; num_blocks = 16'd1;
                end
                @(negedge clk);
                start = 1'b0;
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, e_out[i]);
                chk("stall_last", bus.out_last, 64'(i == n - 1));
                chk("stall_in_ready", bus.in_ready, 0);
                chk("stall_busy", busy, 1);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("valid_clr", bus.out_valid, 0);
        end
        chk("done", done, 1);
        chk("cstart_count", 64'(cs_cnt - cs0), 64'(n));
        chk("wrap_end", ctr_wrap, 64'(e_wrap[n-1]));
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_cstart"}, bus.cipher_start, 0);
        chk({tag, "_cipher_in"}, bus.cipher_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ctr_wrap"}, ctr_wrap, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int w;
        logic [1:0] rm;
        int rn;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        reset = 1'b0;
        @(negedge clk);

        // CTR, iv=1, two zero blocks
        pt[0] = '0; pt[1] = '0;
        run_msg(2'b00, 1'b0, 64'h1, 2, 0, 1'b0);
        chk("ctr_blk0", res[0], 64'hA5A5_A5A5_A5A5_A5A4);
        chk("ctr_blk1", res[1], 64'hA5A5_A5A5_A5A5_A5A7);

        // CTR low-field wrap
        pt[0] = {$urandom, $urandom}; pt[1] = {$urandom, $urandom};
        run_msg(2'b00, 1'b0, 64'h0000_0001_FFFF_FFFF, 2, 1, 1'b0);
        chk("wrap_sticky", ctr_wrap, 1);

        // OFB, iv=0, zeros
        pt[0] = '0; pt[1] = '0;
        run_msg(2'b01, 1'b0, 64'h0, 2, 0, 1'b0);
        chk("ofb_blk0", res[0], K);
        chk("ofb_blk1", res[1], 64'h0);
        chk("ofb_wrap_clr", ctr_wrap, 0);

        // CFB encrypt then decrypt round trip
        iv = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin pt[i] = {$urandom, $urandom}; orig[i] = pt[i]; end
        begin
            logic [63:0] civ;
            civ = {$urandom, $urandom};
            run_msg(2'b10, 1'b0, civ, 4, -1, 1'b0);
            for (int i = 0; i < 4; i++) pt[i] = res[i];
            run_msg(2'b10, 1'b1, civ, 4, -1, 1'b0);
            for (int i = 0; i < 4; i++) chk("cfb_roundtrip", res[i], orig[i]);
        end

        // Backpressure with ignored mid-message start
        for (int i = 0; i < 3; i++) pt[i] = {$urandom, $urandom};
        run_msg(2'b01, 1'b0, {$urandom, $urandom}, 3, 5, 1'b1);

        // Random messages
        for (int t = 0; t < 6; t++) begin
            rm = 2'($urandom_range(0, 2));
            rn = $urandom_range(1, 5);
            for (int i = 0; i < rn; i++) pt[i] = {$urandom, $urandom};
            run_msg(rm, 1'($urandom), {$urandom, $urandom}, rn, -1, 1'($urandom));
        end

        // Illegal mode
        mode = 2'b11; num_blocks = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_clear", err, 0);
        chk("err_idle", busy, 0);
        chk("err_no_cstart", bus.cipher_start, 0);

        // Zero-length message
        mode = 2'b00; num_blocks = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_no_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("zero_done_clr", done, 0);
        chk("zero_idle", busy, 0);
        chk("zero_no_valid2", bus.out_valid, 0);

        // Reset while waiting on the cipher core, leaving ctr_wrap set first
        pt[0] = '0;
        run_msg(2'b00, 1'b0, 64'h0000_0003_FFFF_FFFF, 1, 0, 1'b0);
        mode = 2'b00; iv = 64'h0000_0003_FFFF_FFFF; num_blocks = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!bus.cipher_start && w < 20) begin @(negedge clk); w++; end
        chk("pre_reset_cstart", bus.cipher_start, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_outs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) pt[i] = {$urandom, $urandom};
        run_msg(2'b00, 1'b0, 64'h1234_5678_0000_0010, 3, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
